// File: rtl/seg7_scan_if.sv
// rtl/seg7_scan_if.sv - digit load/control inputs and display drive outputs of seg7_scan
interface seg7_scan_if;
  logic       load;
  logic [3:0] ones0;
  logic [3:0] tens0;
  logic [3:0] ones1;
  logic [3:0] tens1;
  logic       blank_lz;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame;

  modport master (
    output load, ones0, tens0, ones1, tens1, blank_lz,
    input  an, seg, frame
  );

  modport slave (
    input  load, ones0, tens0, ones1, tens1, blank_lz,
    output an, seg, frame
  );
endinterface

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - four-digit common-anode seven-segment scanner with shadowed BCD digits
module seg7_scan #(
  parameter int DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  seg7_scan_if.slave  bus
);

  localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    s_o0_q, s_o0_d, s_t0_q, s_t0_d;
  logic [3:0]    s_o1_q, s_o1_d, s_t1_q, s_t1_d;
  logic          wrap_q, wrap_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          frame_q, frame_d;
  logic          tick;
  logic [3:0]    val;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  always_comb begin
    tick   = (cnt_q == CNT_MAX);
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    idx_d  = tick ? idx_q + 2'd1 : idx_q;
    s_o0_d = bus.load ? bus.ones0 : s_o0_q;
    s_t0_d = bus.load ? bus.tens0 : s_t0_q;
    s_o1_d = bus.load ? bus.ones1 : s_o1_q;
    s_t1_d = bus.load ? bus.tens1 : s_t1_q;
    // wrap_q marks that idx has just returned to 0; frame lands with the digit-0 output one edge later
    wrap_d  = tick && (idx_q == 2'd3);
    frame_d = wrap_q;

    case (idx_q)
      2'd0:    val = s_o0_q;
      2'd1:    val = s_t0_q;
      2'd2:    val = s_o1_q;
      default: val = s_t1_q;
    endcase

    if (bus.blank_lz && idx_q[0] && (val == 4'd0)) begin
      an_d  = 4'b1111;
      seg_d = 7'b1111111;
    end else begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = decode(val);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      s_o0_q  <= 4'd0;
      s_t0_q  <= 4'd0;
      s_o1_q  <= 4'd0;
      s_t1_q  <= 4'd0;
      wrap_q  <= 1'b0;
      an_q    <= 4'b1111;
      seg_q   <= 7'b1111111;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      s_o0_q  <= s_o0_d;
      s_t0_q  <= s_t0_d;
      s_o1_q  <= s_o1_d;
      s_t1_q  <= s_t1_d;
      wrap_q  <= wrap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      frame_q <= frame_d;
    end
  end

  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.frame = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - directed bench for seg7_scan at DIV=4 (ifa) and DIV=1 (ifb)
module tb_seg7_scan;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   c;

  logic [6:0] seg_tab [16];
  logic [3:0] an_tab  [4];

  seg7_scan_if ifa ();
  seg7_scan_if ifb ();

  seg7_scan #(.DIV(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  seg7_scan #(.DIV(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    c++;
  endtask

  // Observe A for cycles c0..c1; slot n shows segs[n] unless blank_mask[n] is set
  task automatic scan_a(input int c1, input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] blank_mask);
    int slot;
    logic [6:0] se;
    while (c < c1) begin
      step();
      slot = (c / 4) % 4;
      se = (slot == 0) ? s0 : (slot == 1) ? s1 : (slot == 2) ? s2 : s3;
      if (blank_mask[slot]) begin
        chk($sformatf("a_an c=%0d", c), 16'(ifa.an), 16'hF);
        chk($sformatf("a_seg c=%0d", c), 16'(ifa.seg), 16'h7F);
      end else begin
        chk($sformatf("a_an c=%0d", c), 16'(ifa.an), 16'(an_tab[slot]));
        chk($sformatf("a_seg c=%0d", c), 16'(ifa.seg), 16'(se));
      end
      chk($sformatf("a_frame c=%0d", c), 16'(ifa.frame), 16'((c % 16) == 0));
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    c = 0;
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0111111;
    an_tab[0] = 4'b1110; an_tab[1] = 4'b1101; an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;

    rst_n = 1'b0;
    {ifa.load, ifa.ones0, ifa.tens0, ifa.ones1, ifa.tens1, ifa.blank_lz} = '0;
    {ifb.load, ifb.ones0, ifb.tens0, ifb.ones1, ifb.tens1, ifb.blank_lz} = '0;
    repeat (3) @(negedge clk);
    chk("rst_a_an", 16'(ifa.an), 16'hF);
    chk("rst_a_seg", 16'(ifa.seg), 16'h7F);
    chk("rst_a_frame", 16'(ifa.frame), 16'h0);
    chk("rst_b_an", 16'(ifb.an), 16'hF);

    // Release with a load pending: first edge shows digit 0 with the pre-load shadow (0)
    ifa.tens1 = 4'd4; ifa.ones1 = 4'd2; ifa.tens0 = 4'd0; ifa.ones0 = 4'd7; ifa.load = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("first_an", 16'(ifa.an), 16'hE);
    chk("first_seg", 16'(ifa.seg), 16'h40);
    chk("first_frame", 16'(ifa.frame), 16'h0);
    ifa.load = 1'b0;

    scan_a(40, seg_tab[7], seg_tab[0], seg_tab[2], seg_tab[4], 4'b0000);

    ifa.blank_lz = 1'b1;
    scan_a(56, seg_tab[7], seg_tab[0], seg_tab[2], seg_tab[4], 4'b0010);

    ifa.tens1 = 4'd0; ifa.ones0 = 4'd0; ifa.load = 1'b1;
    step();
    chk("lz_load_an", 16'(ifa.an), 16'hB);
    chk("lz_load_seg", 16'(ifa.seg), 16'(seg_tab[2]));
    ifa.load = 1'b0;
    scan_a(72, seg_tab[0], seg_tab[0], seg_tab[2], seg_tab[0], 4'b1010);

    ifa.ones0 = 4'hC; ifa.tens0 = 4'hF; ifa.load = 1'b1;
    step();
    chk("inv_load_an", 16'(ifa.an), 16'hB);
    ifa.load = 1'b0;
    scan_a(88, 7'b0111111, 7'b0111111, seg_tab[2], seg_tab[0], 4'b1000);

    // Mid-scan reset must clear outputs without waiting for a clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_an", 16'(ifa.an), 16'hF);
    chk("async_rst_seg", 16'(ifa.seg), 16'h7F);
    chk("async_rst_frame", 16'(ifa.frame), 16'h0);
    ifa.blank_lz = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("held_rst_an", 16'(ifa.an), 16'hF);
    rst_n = 1'b1;

    for (int r = 0; r <= 16; r++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("r_a_an r=%0d", r), 16'(ifa.an), 16'(an_tab[(r / 4) % 4]));
      chk($sformatf("r_a_seg r=%0d", r), 16'(ifa.seg), 16'h40);
      chk($sformatf("r_a_frame r=%0d", r), 16'(ifa.frame), 16'(r == 16));
      chk($sformatf("b_an r=%0d", r), 16'(ifb.an), 16'(an_tab[r % 4]));
      chk($sformatf("b_frame r=%0d", r), 16'(ifb.frame), 16'((r % 4 == 0) && (r > 0)));
      if (r % 4 == 2)
        chk($sformatf("b_seg r=%0d", r), 16'(ifb.seg), 16'(seg_tab[(r + 3) % 16]));
      else
        chk($sformatf("b_seg r=%0d", r), 16'(ifb.seg), 16'h40);
      ifb.load = 1'b1;
      ifb.ones1 = 4'((r + 5) % 16);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
